nv_nvdla_rubik_drc_pack: RTL
============================

NV_NVDLA_RUBIK_DRC_PACK -- requirements
Module: NV_NVDLA_RUBIK_drc_pack

Interface
REQ-001 SHALL have port nvdla_core_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port nvdla_core_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port in_vld, input, 1 bit: upstream beat valid (DMA read-data fifo output).
REQ-004 SHALL have port in_rdy, output, 1 bit: beat accepted when in_vld & in_rdy.
REQ-005 SHALL have port in_pd, input, 512 bits: [255:0] low half, [511:256] high half.
REQ-006 SHALL have port in_mask, input, 2 bits: bit0 low half valid, bit1 high half valid.
REQ-007 SHALL have port in_last, input, 1 bit: final beat of a surface transfer.
REQ-008 SHALL have port out_vld, output, 1 bit: packed word valid.
REQ-009 SHALL have port out_rdy, input, 1 bit: downstream ready.
REQ-010 SHALL have port out_pd, output, 512 bits: packed word; [255:0] older half, [511:256] younger half.
REQ-011 SHALL have port out_mask, output, 2 bits: 2'b11 full word, 2'b01 padded final word.
REQ-012 SHALL have port out_last, output, 1 bit: last packed word of the transfer.

Function
REQ-013 SHALL extract the valid halves of each accepted beat in order low half then high half; invalid halves are discarded.
REQ-014 SHALL keep one 256-bit hold register (hold_pd) plus state IDLE (hold empty), HALF (hold full), FLUSH (hold full, padded word owed).
REQ-015 SHALL register outputs in a single output stage (out_vld/out_pd/out_mask/out_last); the stage is free when !out_vld | out_rdy.
REQ-016 SHALL drive in_rdy = stage free & state != FLUSH & !nvdla_core_rst.
REQ-017 SHALL form, on acceptance, the half sequence S = {hold_pd if HALF, valid halves of beat}; |S| ranges 0..3.
REQ-018 SHALL, when |S| >= 2, load the output stage next cycle with {S[1],S[0]}, out_mask 2'b11; S[2] (if any) goes to hold_pd, state HALF; else state IDLE.
REQ-019 SHALL, when |S| == 1, store S[0] in hold_pd, state HALF, and produce no output unless in_last.
REQ-020 SHALL, when |S| == 1 and in_last, output {256'h0,S[0]}, out_mask 2'b01, out_last 1, state IDLE.
REQ-021 SHALL, when |S| == 0 (mask 2'b00, state IDLE), consume the beat with no output; if in_last, no out_last word is produced.
REQ-022 SHALL, when |S| == 2 and in_last, output the full word with out_last 1, state IDLE.
REQ-023 SHALL, when |S| == 3 and in_last, output the full word with out_last 0, move S[2] to hold_pd, enter FLUSH.
REQ-024 SHALL, in FLUSH, when the stage is free, output {256'h0,hold_pd}, out_mask 2'b01, out_last 1, and return to IDLE.
REQ-025 SHALL have latency one cycle from accepting a word-completing beat to out_vld high.
REQ-026 SHALL hold out_pd/out_mask/out_last stable while out_vld & !out_rdy.
REQ-027 SHALL sustain one beat per cycle when out_rdy is held high and no FLUSH occurs.

Reset
REQ-028 SHALL, while nvdla_core_rst is high: out_vld 0, out_pd 0, out_mask 0, out_last 0, hold_pd 0, state IDLE, in_rdy 0.
REQ-029 SHALL, on reset asserted mid-transfer, discard held and staged data immediately, with no partial word emitted after release.
REQ-030 SHALL assert in_rdy high the first cycle after reset release.

Verification
REQ-031 SHALL cover: mask 11 beats A,B back-to-back, out_rdy=1 -> two words {A.h,A.l},{B.h,B.l}, one cycle after each accept, mask 11.
REQ-032 SHALL cover: masks 01(X),10(Y),01(Z,last) -> word {Y.h,X.l} mask 11 last 0, then {0,Z.l} mask 01 last 1.
REQ-033 SHALL cover: hold full, then mask 11 beat W with last -> {W.l,hold} last 0, in_rdy low one slot, then {0,W.h} mask 01 last 1.
REQ-034 SHALL cover: out_rdy=0 for 5 cycles with output staged -> in_rdy 0, out_pd unchanged; release -> drain, no loss/duplication.
REQ-035 SHALL cover: mask 00 beats interleaved with mask 01 beats -> 00 beats consumed silently, halves paired correctly.
REQ-036 SHALL cover: reset pulsed while in HALF with out_vld=1 -> out_vld 0 asynchronously; next full beat after release outputs only its own halves.

Source files
------------

// File: rtl/nv_nvdla_rubik_drc_pack.sv
// Packs 256-bit halves from masked 512-bit DMA beats into dense 512-bit words.
// A lone trailing half at the end of a transfer is emitted as a padded word with mask 2'b01.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | hold register empty
// HALF   | hold register carries one half waiting for a partner
// FLUSH  | hold register carries the final half; a padded last word is still owed
module nv_nvdla_rubik_drc_pack (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [511:0] in_pd,
    input  logic [1:0]   in_mask,
    input  logic         in_last,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [511:0] out_pd,
    output logic [1:0]   out_mask,
    output logic         out_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [255:0] hold_pd;
    logic [255:0] hold_nxt;

    logic         stage_free;
    logic         accept;
    logic         have_hold;
    logic [1:0]   n_half;
    logic [255:0] half_lo;
    logic [255:0] half_hi;
    logic [255:0] s0;
    logic [255:0] s1;
    logic [255:0] s2;

    logic         load;
    logic [511:0] ld_pd;
    logic [1:0]   ld_mask;
    logic         ld_last;

    assign stage_free = !out_vld || out_rdy;
    assign in_rdy     = stage_free && (state != ST_FLUSH) && !nvdla_core_rst;
    assign accept     = in_vld && in_rdy;
    assign have_hold  = (state == ST_HALF);

    assign half_lo = in_pd[255:0];
    assign half_hi = in_pd[511:256];

    assign n_half = {1'b0, have_hold} + {1'b0, in_mask[0]} + {1'b0, in_mask[1]};

    // Half sequence: held half first, then the beat's low half, then its high half.
    assign s0 = have_hold ? hold_pd : (in_mask[0] ? half_lo : half_hi);
    assign s1 = have_hold ? (in_mask[0] ? half_lo : half_hi) : half_hi;
    assign s2 = half_hi;

    always_comb begin
        state_nxt = ((state == ST_HALF) || (state == ST_FLUSH)) ? state : ST_IDLE;
        hold_nxt  = hold_pd;
        load      = 1'b0;
        ld_pd     = '0;
        ld_mask   = 2'b00;
        ld_last   = 1'b0;

        if (state == ST_FLUSH) begin
            if (stage_free) begin
                load      = 1'b1;
                ld_pd     = {256'h0, hold_pd};
                ld_mask   = 2'b01;
                ld_last   = 1'b1;
                state_nxt = ST_IDLE;
            end
        end else if (accept) begin
            case (n_half)
                2'd3: begin
                    load      = 1'b1;
                    ld_pd     = {s1, s0};
                    ld_mask   = 2'b11;
                    ld_last   = 1'b0;
                    hold_nxt  = s2;
                    state_nxt = in_last ? ST_FLUSH : ST_HALF;
                end
                2'd2: begin
                    load      = 1'b1;
                    ld_pd     = {s1, s0};
                    ld_mask   = 2'b11;
                    ld_last   = in_last;
                    state_nxt = ST_IDLE;
                end
                2'd1: begin
                    hold_nxt = s0;
                    if (in_last) begin
                        load      = 1'b1;
                        ld_pd     = {256'h0, s0};
                        ld_mask   = 2'b01;
                        ld_last   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_HALF;
                    end
                end
                // An empty beat carries nothing, including its last marker.
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state   <= ST_IDLE;
            hold_pd <= '0;
        end else begin
            state   <= state_nxt;
            hold_pd <= hold_nxt;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            out_vld  <= 1'b0;
            out_pd   <= '0;
            out_mask <= 2'b00;
            out_last <= 1'b0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_pd   <= ld_pd;
            out_mask <= ld_mask;
            out_last <= ld_last;
        end else if (stage_free) begin
            out_vld  <= 1'b0;
        end
    end

endmodule
